// File: rtl/counter_bn.sv
// counter_bn: WIDTH-generic up/down/step/load counter.
// It can saturate at the range limits or wrap around, and it has a carry-in /
// terminal-count pair so that several stages can be chained into a wider counter.
// cn_Q, cn_load and cn_rco are registered. cn_tc is combinational, so a chained
// stage sees the carry in the same cycle as the stage that drives it.

module counter_bn #(
    parameter int WIDTH = 8,
    parameter int STEP  = 3
) (
    input  logic             cn_clk,
    input  logic             cn_reset_n,
    input  logic             cn_enable,
    input  logic             cn_cin,
    input  logic [1:0]       cn_mode,
    input  logic             cn_sat,
    input  logic [WIDTH-1:0] cn_D,
    output logic [WIDTH-1:0] cn_Q,
    output logic             cn_load,
    output logic             cn_rco,
    output logic             cn_tc
);

    localparam logic [1:0]     MODE_UP   = 2'b00;
    localparam logic [1:0]     MODE_DOWN = 2'b01;
    localparam logic [1:0]     MODE_STEP = 2'b10;
    localparam logic [1:0]     MODE_LOAD = 2'b11;
    localparam logic [WIDTH:0] ONE_W     = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] STEP_W    = (WIDTH+1)'(STEP);

    logic [WIDTH-1:0] q_r;
    logic             load_r;
    logic             rco_r;

    logic [WIDTH:0]   inc_s;
    logic [WIDTH:0]   up_sum_s;
    logic [WIDTH:0]   dn_diff_s;
    logic             event_s;
    logic [WIDTH-1:0] count_s;
    logic [WIDTH-1:0] limit_s;
    logic [WIDTH-1:0] q_nxt_s;
    logic             load_nxt_s;
    logic             rco_nxt_s;
    logic             tc_s;

    // Arithmetic is done one bit wider than the count, so that bit WIDTH
    // holds the carry (up) or the borrow (down).
    always_comb begin
        inc_s     = (cn_mode == MODE_STEP) ? STEP_W : ONE_W;
        up_sum_s  = {1'b0, q_r} + inc_s;
        dn_diff_s = {1'b0, q_r} - inc_s;
        if (cn_mode == MODE_DOWN) begin
            event_s = dn_diff_s[WIDTH];
            count_s = dn_diff_s[WIDTH-1:0];
            limit_s = {WIDTH{1'b0}};
        end else begin
            event_s = up_sum_s[WIDTH];
            count_s = up_sum_s[WIDTH-1:0];
            limit_s = {WIDTH{1'b1}};
        end
    end

    // Terminal count drives the next stage's carry-in. It never asserts in load mode.
    always_comb begin
        tc_s = cn_enable & cn_cin & event_s & (cn_mode != MODE_LOAD);
    end

    // Next-state selection. Enable comes first, then load, then gated counting.
    always_comb begin
        q_nxt_s    = q_r;
        load_nxt_s = 1'b0;
        rco_nxt_s  = 1'b0;
        if (!cn_enable) begin
            q_nxt_s = q_r;
        end else begin
            case (cn_mode)
                MODE_LOAD: begin
                    q_nxt_s    = cn_D;
                    load_nxt_s = 1'b1;
                end
                MODE_UP, MODE_DOWN, MODE_STEP: begin
                    if (cn_cin) begin
                        rco_nxt_s = event_s;
                        if (cn_sat && event_s) begin
                            q_nxt_s = limit_s;
                        end else begin
                            q_nxt_s = count_s;
                        end
                    end else begin
                        q_nxt_s = q_r;
                    end
                end
                default: begin
                    q_nxt_s = q_r;
                end
            endcase
        end
    end

    // State register. Reset clears the count and both pulse flags at once.
    always_ff @(posedge cn_clk or negedge cn_reset_n) begin
        if (!cn_reset_n) begin
            q_r    <= {WIDTH{1'b0}};
            load_r <= 1'b0;
            rco_r  <= 1'b0;
        end else begin
            q_r    <= q_nxt_s;
            load_r <= load_nxt_s;
            rco_r  <= rco_nxt_s;
        end
    end

    assign cn_Q    = q_r;
    assign cn_load = load_r;
    assign cn_rco  = rco_r;
    assign cn_tc   = tc_s;

endmodule

// File: tb/tb_counter_bn.sv
// Directed testbench for counter_bn. It uses an 8-bit instance with STEP=3 and
// two 4-bit instances chained together.

module tb_counter_bn;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       cin;
    logic [1:0] mode;
    logic       sat;
    logic [7:0] d;
    logic [7:0] q;
    logic       ld;
    logic       rco;
    logic       tc;

    logic       c_en;
    logic       c_cin;
    logic [1:0] c_mode;
    logic [3:0] c_dl;
    logic [3:0] c_dh;
    logic [3:0] c_ql;
    logic [3:0] c_qh;
    logic       c_ldl, c_rcol, c_tcl;
    logic       c_ldh, c_rcoh, c_tch;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    counter_bn #(.WIDTH(8), .STEP(3)) dut (
        .cn_clk(clk), .cn_reset_n(rst_n), .cn_enable(en), .cn_cin(cin),
        .cn_mode(mode), .cn_sat(sat), .cn_D(d), .cn_Q(q),
        .cn_load(ld), .cn_rco(rco), .cn_tc(tc)
    );

    counter_bn #(.WIDTH(4), .STEP(3)) u_lo (
        .cn_clk(clk), .cn_reset_n(rst_n), .cn_enable(c_en), .cn_cin(c_cin),
        .cn_mode(c_mode), .cn_sat(1'b0), .cn_D(c_dl), .cn_Q(c_ql),
        .cn_load(c_ldl), .cn_rco(c_rcol), .cn_tc(c_tcl)
    );

    counter_bn #(.WIDTH(4), .STEP(3)) u_hi (
        .cn_clk(clk), .cn_reset_n(rst_n), .cn_enable(c_en), .cn_cin(c_tcl),
        .cn_mode(c_mode), .cn_sat(1'b0), .cn_D(c_dh), .cn_Q(c_qh),
        .cn_load(c_ldh), .cn_rco(c_rcoh), .cn_tc(c_tch)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_value(input logic [7:0] v);
        en   = 1'b1;
        mode = 2'b11;
        d    = v;
        tick();
    endtask

    task automatic test_reset;
        rst_n = 1'b0; en = 1'b0; cin = 1'b0; mode = 2'b00; sat = 1'b0; d = 8'h00;
        c_en = 1'b0; c_cin = 1'b0; c_mode = 2'b00; c_dl = 4'h0; c_dh = 4'h0;
        tick(); tick();
        n_tests++;
        if ({q, ld, rco} !== {8'h00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_initial: got q=%h ld=%b rco=%b, want 00 0 0", q, ld, rco);
        end
        rst_n = 1'b1;
        load_value(8'h58);
        mode = 2'b00; cin = 1'b1;
        tick(); tick();
        n_tests++;
        if (q !== 8'h5A) begin
            n_fail++;
            $display("FAIL reset_precount: got q=%h, want 5a", q);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({q, ld, rco} !== {8'h00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_async: got q=%h ld=%b rco=%b, want 00 0 0", q, ld, rco);
        end
        tick();
        n_tests++;
        if ({q, ld, rco} !== {8'h00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_held: got q=%h ld=%b rco=%b, want 00 0 0", q, ld, rco);
        end
        en = 1'b0;
        #2 rst_n = 1'b1;
        tick(); tick();
        n_tests++;
        if ({q, ld, rco} !== {8'h00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_release_hold: got q=%h ld=%b rco=%b, want 00 0 0", q, ld, rco);
        end
    endtask

    task automatic test_load_count_up;
        logic [10:0] ev [0:4];
        ev = '{{8'hFD, 3'b100}, {8'hFE, 3'b000}, {8'hFF, 3'b001},
               {8'h00, 3'b010}, {8'h01, 3'b000}};
        sat = 1'b0;
        load_value(8'hFD);
        mode = 2'b00; cin = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            n_tests++;
            if ({q, ld, rco, tc} !== ev[i]) begin
                n_fail++;
                $display("FAIL load_count_up[%0d]: got q/ld/rco/tc=%h, want %h", i, {q, ld, rco, tc}, ev[i]);
            end
        end
    endtask

    task automatic test_down_saturate;
        logic [10:0] ev [0:4];
        ev = '{{8'h02, 3'b100}, {8'h01, 3'b000}, {8'h00, 3'b001},
               {8'h00, 3'b011}, {8'h00, 3'b011}};
        load_value(8'h02);
        mode = 2'b01; sat = 1'b1; cin = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            n_tests++;
            if ({q, ld, rco, tc} !== ev[i]) begin
                n_fail++;
                $display("FAIL down_saturate[%0d]: got q/ld/rco/tc=%h, want %h", i, {q, ld, rco, tc}, ev[i]);
            end
        end
    endtask

    task automatic test_step;
        logic [10:0] ev_wrap [0:3];
        logic [10:0] ev_sat  [0:2];
        ev_wrap = '{{8'hFC, 3'b100}, {8'hFF, 3'b001}, {8'h02, 3'b010}, {8'h05, 3'b000}};
        ev_sat  = '{{8'hFC, 3'b100}, {8'hFF, 3'b001}, {8'hFF, 3'b011}};
        load_value(8'hFC);
        mode = 2'b10; sat = 1'b0; cin = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            n_tests++;
            if ({q, ld, rco, tc} !== ev_wrap[i]) begin
                n_fail++;
                $display("FAIL step_wrap[%0d]: got q/ld/rco/tc=%h, want %h", i, {q, ld, rco, tc}, ev_wrap[i]);
            end
        end
        load_value(8'hFC);
        mode = 2'b10; sat = 1'b1; cin = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            n_tests++;
            if ({q, ld, rco, tc} !== ev_sat[i]) begin
                n_fail++;
                $display("FAIL step_sat[%0d]: got q/ld/rco/tc=%h, want %h", i, {q, ld, rco, tc}, ev_sat[i]);
            end
        end
    endtask

    task automatic test_gating;
        sat = 1'b0;
        load_value(8'h10);
        mode = 2'b00; cin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if ({q, ld, rco, tc} !== {8'h10, 3'b000}) begin
                n_fail++;
                $display("FAIL cin_gate[%0d]: got q/ld/rco/tc=%h, want 100", i, {q, ld, rco, tc});
            end
        end
        en = 1'b0; mode = 2'b11; d = 8'hAA;
        tick();
        n_tests++;
        if ({q, ld, rco, tc} !== {8'h10, 3'b000}) begin
            n_fail++;
            $display("FAIL enable_blocks_load: got q/ld/rco/tc=%h, want 100", {q, ld, rco, tc});
        end
        load_value(8'hFF);
        mode = 2'b00; cin = 1'b1;
        tick();
        n_tests++;
        if ({q, rco} !== {8'h00, 1'b1}) begin
            n_fail++;
            $display("FAIL enable_pre_wrap: got q=%h rco=%b, want 00 1", q, rco);
        end
        en = 1'b0;
        tick();
        n_tests++;
        if ({q, ld, rco} !== {8'h00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL enable_clears_rco: got q=%h ld=%b rco=%b, want 00 0 0", q, ld, rco);
        end
    endtask

    task automatic test_cascade;
        logic [8:0] ev [0:3];
        ev = '{{8'h0E, 1'b0}, {8'h0F, 1'b1}, {8'h10, 1'b0}, {8'h11, 1'b0}};
        c_en = 1'b1; c_cin = 1'b1; c_mode = 2'b11; c_dl = 4'hE; c_dh = 4'h0;
        tick();
        c_mode = 2'b00;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            n_tests++;
            if ({c_qh, c_ql, c_tcl} !== ev[i]) begin
                n_fail++;
                $display("FAIL cascade[%0d]: got hi/lo/tc=%h, want %h", i, {c_qh, c_ql, c_tcl}, ev[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_count_up();
        test_down_saturate();
        test_step();
        test_gating();
        test_cascade();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
